// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter
// Round-robin write sequencer for a bank of D/L/C registers shared by two
// requesters. A granted write walks LOAD -> CHECK -> ACK. LOAD pulses one
// load enable. CHECK compares the readback with the written data. ACK returns
// a one-cycle ack with the verify result. The block is the only driver of the
// bank's load, data and select lines.

module reg_bank_write_arbiter #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              C,
  input  logic              nR,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  output logic              ack0,
  output logic              err0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              ack1,
  output logic              err1,
  output logic [DEPTH-1:0]  bank_l,
  output logic [WIDTH-1:0]  bank_d,
  output logic [ADDR_W-1:0] bank_sel,
  input  logic [WIDTH-1:0]  bank_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    ACK   = 2'd3
  } state_t;

  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t state;
  logic   ptr;       // requester preferred when both ask at once
  logic   gnt;       // requester owning the current transaction
  logic   bad_q;     // current transaction targets a non-existent register

  logic              pick;
  logic [ADDR_W-1:0] pick_addr;
  logic [WIDTH-1:0]  pick_data;
  logic              pick_bad;
  logic [DEPTH-1:0]  pick_onehot;
  logic              mismatch;

  // Grant choice and the load vector the winner would drive next cycle.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    pick        = 1'b0;
    pick_onehot = '0;
    if (req0 && req1) pick = ptr;
    else              pick = req1;
    pick_addr = pick ? addr1 : addr0;
    pick_data = pick ? data1 : data0;
    pick_bad  = ({1'b0, pick_addr} >= DEPTH_LIM);
    // Addresses at or beyond DEPTH match no bit, so the vector stays zero.
    for (int i = 0; i < DEPTH; i++) begin
      pick_onehot[i] = (pick_addr == ADDR_W'(i));
    end
  end

  // Readback verdict. bank_d and bank_sel still hold the granted write.
  assign mismatch = (bank_q != bank_d) || bad_q;

  // Transaction sequencer with registered bank and handshake outputs.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      bad_q    <= 1'b0;
      ack0     <= 1'b0;
      err0     <= 1'b0;
      ack1     <= 1'b0;
      err1     <= 1'b0;
      bank_l   <= '0;
      bank_d   <= '0;
      bank_sel <= '0;
      busy     <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments. Every register
      // then sees the pre-edge values, whatever order the statements are in.
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt      <= pick;
            bank_sel <= pick_addr;
            bank_d   <= pick_data;
            bank_l   <= pick_onehot;
            bad_q    <= pick_bad;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          // The register captures bank_d on this edge. Drop the enable now.
          bank_l <= '0;
          state  <= CHECK;
        end
        CHECK: begin
          if (gnt) begin
            ack1 <= 1'b1;
            err1 <= mismatch;
          end else begin
            ack0 <= 1'b1;
            err0 <= mismatch;
          end
          state <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          err0  <= 1'b0;
          ack1  <= 1'b0;
          err1  <= 1'b0;
          ptr   <= ~gnt;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Structural invariants of the handshake and load vector.
  a_load_onehot0 : assert property (@(posedge C) disable iff (!nR) $onehot0(bank_l));
  a_single_ack   : assert property (@(posedge C) disable iff (!nR) !(ack0 && ack1));
  a_err0_qual    : assert property (@(posedge C) disable iff (!nR) err0 |-> ack0);
  a_err1_qual    : assert property (@(posedge C) disable iff (!nR) err1 |-> ack1);

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Testbench for reg_bank_write_arbiter. A behavioural register bank answers
// bank_q. Register 7 has bit 0 stuck at 0. A transaction-level model predicts
// every output each cycle. Directed scenarios pin the model with literal
// expectations.

module tb_reg_bank_write_arbiter;

  localparam int W  = 32;
  localparam int DP = 24;
  localparam int AW = 5;

  logic          C = 1'b0;
  logic          nR = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0]  data0 = '0, data1 = '0;
  logic          ack0, err0, ack1, err1, busy;
  logic [DP-1:0] bank_l;
  logic [W-1:0]  bank_d, bank_q;
  logic [AW-1:0] bank_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ack0   = 0;
  int n_ack1   = 0;

  always #5 C = ~C;

  reg_bank_write_arbiter #(.WIDTH(W), .DEPTH(DP), .ADDR_W(AW)) dut (
    .C(C), .nR(nR),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1), .err1(err1),
    .bank_l(bank_l), .bank_d(bank_d), .bank_sel(bank_sel), .bank_q(bank_q),
    .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value a register holds after writing d into register a.
  function automatic logic [W-1:0] stored(input int a, input logic [W-1:0] d);
    return (a == 7) ? (d & ~32'h1) : d;
  endfunction

  // Register bank: captures on the edge while its load enable is high.
  logic [W-1:0] mem [DP] = '{default: '0};
  always @(posedge C) begin
    for (int i = 0; i < DP; i++) if (bank_l[i]) mem[i] <= stored(i, bank_d);
  end
  always_comb begin
    bank_q = '0;
    if (int'(bank_sel) < DP) bank_q = mem[int'(bank_sel)];
  end

  always @(posedge C) cyc++;
  always @(negedge C) begin
    if (ack0 === 1'b1) n_ack0++;
    if (ack1 === 1'b1) n_ack1++;
  end

  // Transaction model. A write granted at edge g occupies edges g..g+3:
  // load pulse after g, ack after g+2, and the next grant no earlier than g+4.
  bit            m_act, m_ptr, m_id, m_bad, m_err;
  int            m_age;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;

  always @(posedge C or negedge nR) begin
    if (!nR) begin
      m_act = 0; m_ptr = 0; m_id = 0; m_bad = 0; m_err = 0; m_age = 0;
      m_addr = '0; m_data = '0;
    end else if (m_act) begin
      m_age++;
      if (m_age == 3) begin
        m_act = 0;
        m_ptr = !m_id;
      end
    end else if (req0 || req1) begin
      if (req0 && req1) m_id = m_ptr;
      else if (req0)    m_id = 0;
      else              m_id = 1;
      m_addr = m_id ? addr1 : addr0;
      m_data = m_id ? data1 : data0;
      m_bad  = int'(m_addr) >= DP;
      m_err  = m_bad || (stored(int'(m_addr), m_data) != m_data);
      m_act  = 1;
      m_age  = 0;
    end
  end

  // Compare process: every output against the model, once per cycle.
  logic [DP-1:0] e_l;
  logic          e_busy, e_a0, e_a1, e_e0, e_e1;
  always @(negedge C) begin
    if (nR) begin
      e_l = '0; e_busy = 0; e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0;
      if (m_act) begin
        e_busy = 1;
        if (m_age == 0 && !m_bad) e_l[m_addr] = 1'b1;
        if (m_age == 2) begin
          if (m_id) begin e_a1 = 1; e_e1 = m_err; end
          else      begin e_a0 = 1; e_e0 = m_err; end
        end
      end
      check("bank_l",   bank_l,   e_l);
      check("busy",     busy,     e_busy);
      check("ack0",     ack0,     e_a0);
      check("err0",     err0,     e_e0);
      check("ack1",     ack1,     e_a1);
      check("err1",     err1,     e_e1);
      check("bank_d",   bank_d,   m_data);
      check("bank_sel", bank_sel, m_addr);
    end
  end

  // Wait (bounded) for an ack, then drop that requester's req on the next edge.
  task automatic wait_ack(input bit id, output int at, output logic e,
                          output logic [DP-1:0] l_or, output int l_cnt);
    bit found;
    found = 0; at = -1; e = 1'bx; l_or = '0; l_cnt = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge C);
      l_or |= bank_l;
      if (bank_l != '0) l_cnt++;
      if ((id ? ack1 : ack0) === 1'b1) begin
        found = 1;
        at = cyc;
        e = id ? err1 : err0;
      end
    end
    check(id ? "ack1_seen" : "ack0_seen", found, 1);
    @(posedge C); #1;
    if (id) req1 = 0; else req0 = 0;
  endtask

  task automatic next_cycle();
    @(posedge C); #1;
  endtask

  initial begin
    int t0, t1, t2, t_req, lc, a0s, a1s;
    logic e;
    logic [DP-1:0] lo;

    #2;
    check("rst_ack0", ack0, 0);     check("rst_err0", err0, 0);
    check("rst_ack1", ack1, 0);     check("rst_err1", err1, 0);
    check("rst_bank_l", bank_l, 0); check("rst_bank_d", bank_d, 0);
    check("rst_bank_sel", bank_sel, 0); check("rst_busy", busy, 0);
    repeat (3) @(negedge C);
    nR = 1;

    // Single write to register 5.
    next_cycle();
    req0 = 1; addr0 = 5; data0 = 32'hA5A5_0001; t_req = cyc;
    wait_ack(0, t0, e, lo, lc);
    check("w5_load_vec", lo, 24'h00_0020);
    check("w5_load_cycles", lc, 1);
    check("w5_latency", t0 - t_req, 3);
    check("w5_err", e, 0);
    check("w5_mem", mem[5], 32'hA5A5_0001);

    // Contention from reset: requester 0 first, requester 1 four cycles later.
    @(negedge C); nR = 0;
    req0 = 1; addr0 = 1; data0 = 32'h1111_0001;
    req1 = 1; addr1 = 2; data1 = 32'h2222_0002;
    @(negedge C); nR = 1;
    wait_ack(0, t0, e, lo, lc);
    wait_ack(1, t1, e, lo, lc);
    check("cont_spacing", t1 - t0, 4);
    check("cont_mem1", mem[1], 32'h1111_0001);
    check("cont_mem2", mem[2], 32'h2222_0002);

    // A lone requester-0 write moves the pointer to requester 1.
    next_cycle();
    req0 = 1; addr0 = 3; data0 = 32'h3333_0003;
    wait_ack(0, t0, e, lo, lc);
    next_cycle();
    req0 = 1; addr0 = 4; data0 = 32'h4444_0004;
    req1 = 1; addr1 = 6; data1 = 32'h6666_0006;
    wait_ack(1, t1, e, lo, lc);
    wait_ack(0, t0, e, lo, lc);
    check("rr_req1_first", t0 - t1, 4);
    check("rr_mem4", mem[4], 32'h4444_0004);
    check("rr_mem6", mem[6], 32'h6666_0006);

    // Readback fault on register 7, bit 0 stuck at 0.
    next_cycle();
    req0 = 1; addr0 = 7; data0 = 32'h0000_0001;
    wait_ack(0, t0, e, lo, lc);
    check("stuck_err", e, 1);
    check("stuck_mem7", mem[7], 32'h0);
    next_cycle();
    req0 = 1; addr0 = 7; data0 = 32'h0000_0002;
    wait_ack(0, t0, e, lo, lc);
    check("stuck_ok_err", e, 0);
    check("stuck_ok_mem7", mem[7], 32'h2);

    // Bad address beyond DEPTH.
    next_cycle();
    req1 = 1; addr1 = 30; data1 = 32'hDEAD_BEEF;
    wait_ack(1, t1, e, lo, lc);
    check("bad_err", e, 1);
    check("bad_load_vec", lo, 0);

    // Async reset in the middle of LOAD.
    next_cycle();
    req0 = 1; addr0 = 9; data0 = 32'h9999_0009;
    a0s = n_ack0;
    @(posedge C); #2;
    check("mid_load_vec", bank_l, 24'h00_0200);
    #1 nR = 0;
    #1;
    check("mid_rst_bank_l", bank_l, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack0", ack0, 0);
    req0 = 0;
    @(negedge C); @(negedge C);
    check("mid_rst_mem9", mem[9], 32'h0);
    req0 = 1; addr0 = 9;  data0 = 32'h9999_0009;
    req1 = 1; addr1 = 10; data1 = 32'hAAAA_000A;
    nR = 1;
    check("mid_rst_no_ack", n_ack0, a0s);
    wait_ack(0, t0, e, lo, lc);
    wait_ack(1, t1, e, lo, lc);
    check("post_rst_order", t1 - t0, 4);
    check("post_rst_mem9", mem[9], 32'h9999_0009);
    check("post_rst_mem10", mem[10], 32'hAAAA_000A);

    // Back-to-back writes from requester 0 alone.
    a0s = n_ack0; a1s = n_ack1;
    next_cycle();
    req0 = 1; addr0 = 11; data0 = 32'h0B0B_0001;
    wait_ack(0, t0, e, lo, lc);
    next_cycle();
    req0 = 1; addr0 = 12; data0 = 32'h0C0C_0002;
    wait_ack(0, t1, e, lo, lc);
    next_cycle();
    req0 = 1; addr0 = 13; data0 = 32'h0D0D_0003;
    wait_ack(0, t2, e, lo, lc);
    check("b2b_gap1", t1 - t0, 5);
    check("b2b_gap2", t2 - t1, 5);
    check("b2b_ack0_count", n_ack0 - a0s, 3);
    check("b2b_ack1_count", n_ack1 - a1s, 0);
    check("b2b_mem13", mem[13], 32'h0D0D_0003);

    repeat (4) @(posedge C);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
